// File: rtl/hmc_cmd_responder_if.sv
// Command/write-data/read-response bundle between an HMC traffic initiator
// (master) and the loopback responder (slave).
interface hmc_cmd_responder_if #(
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned SIZE_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 34,
    parameter int unsigned DATA_WIDTH = 128
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [3:0]            cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [SIZE_WIDTH-1:0] size;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_data_valid;
    logic                  wr_data_ready;
    logic                  stall;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [TAG_WIDTH-1:0]  rd_data_tag;
    logic                  rd_data_valid;
    logic [6:0]            errstat;
    logic                  dinv;
    logic [31:0]           rd_count;
    logic [31:0]           wr_count;
    logic [15:0]           err_count;

    modport master (
        output cmd_valid, cmd, addr, size, tag, wr_data, wr_data_valid, stall,
        input  cmd_ready, wr_data_ready, rd_data, rd_data_tag, rd_data_valid,
               errstat, dinv, rd_count, wr_count, err_count
    );

    modport slave (
        input  cmd_valid, cmd, addr, size, tag, wr_data, wr_data_valid, stall,
        output cmd_ready, wr_data_ready, rd_data, rd_data_tag, rd_data_valid,
               errstat, dinv, rd_count, wr_count, err_count
    );
endinterface

// File: rtl/hmc_cmd_responder.sv
// Loopback HMC responder: 16-byte RD/WR into on-chip memory, tagged read responses
// after a fixed LATENCY. Define HMC_RESP_REQ_CHECK_EN to flag bad size/range requests.
module hmc_cmd_responder #(
    parameter int unsigned TAG_WIDTH      = 6,
    parameter int unsigned SIZE_WIDTH     = 4,
    parameter int unsigned ADDR_WIDTH     = 34,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY        = 8,
    parameter logic [3:0]  CMD_WR         = 4'h1,
    parameter logic [3:0]  CMD_RD         = 4'h2
) (
    input logic                rx_clk,
    input logic                rst,
    hmc_cmd_responder_if.slave bus
);
    localparam int unsigned MEM_DEPTH = 2 ** MEM_DEPTH_LOG2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
        logic [6:0]            errstat;
        logic                  dinv;
    } resp_t;

    logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
    logic [MEM_DEPTH_LOG2-1:0] idx;
    logic                      is_rd, is_wr;
    logic                      rd_acc, wr_acc, bad_acc;
    logic                      size_err, range_err, req_err;
    logic                      unused_bits;
    resp_t                     resp_in;
    resp_t                     tail;
    logic                      tail_vld;
    logic [31:0]               rd_count_q, wr_count_q;
    logic [15:0]               err_count_q;

    assign idx   = bus.addr[MEM_DEPTH_LOG2+3:4];
    assign is_rd = (bus.cmd == CMD_RD);
    assign is_wr = (bus.cmd == CMD_WR);

`ifdef HMC_RESP_REQ_CHECK_EN
    assign size_err    = (bus.size != SIZE_WIDTH'(1));
    assign range_err   = |bus.addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+4];
    assign unused_bits = ^bus.addr[3:0];
`else
    assign size_err    = 1'b0;
    assign range_err   = 1'b0;
    assign unused_bits = ^{bus.size, bus.addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+4], bus.addr[3:0]};
`endif
    assign req_err = size_err | range_err;

    // Same-cycle handshake; a write needs command and payload together.
    assign rd_acc  = !rst && !bus.stall && bus.cmd_valid && is_rd;
    assign wr_acc  = !rst && !bus.stall && bus.cmd_valid && is_wr && bus.wr_data_valid;
    assign bad_acc = !rst && !bus.stall && bus.cmd_valid && !is_rd && !is_wr;

    assign bus.cmd_ready     = rd_acc | wr_acc | bad_acc;
    assign bus.wr_data_ready = wr_acc;

    always_ff @(posedge rx_clk) begin
        if (wr_acc && !req_err) begin
            mem[idx] <= bus.wr_data;
        end
    end

    // Size error outranks range error; flagged reads return zero data.
    always_comb begin
        resp_in     = '0;
        resp_in.tag = bus.tag;
        if (size_err) begin
            resp_in.errstat = 7'h01;
            resp_in.dinv    = 1'b1;
        end else if (range_err) begin
            resp_in.errstat = 7'h02;
            resp_in.dinv    = 1'b1;
        end else begin
            resp_in.data = mem[idx];
        end
    end

    // LATENCY-1 delay stages ahead of the output register.
    generate
        if (LATENCY > 1) begin : g_pipe
            resp_t             pipe_q [LATENCY-1];
            logic [LATENCY-2:0] vld_q;

            always_ff @(posedge rx_clk) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    for (int i = LATENCY - 2; i > 0; i--) begin
                        vld_q[i] <= vld_q[i-1];
                    end
                    vld_q[0] <= rd_acc;
                end
            end

            always_ff @(posedge rx_clk) begin
                for (int i = LATENCY - 2; i > 0; i--) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
                pipe_q[0] <= resp_in;
            end

            assign tail_vld = vld_q[LATENCY-2];
            assign tail     = pipe_q[LATENCY-2];
        end else begin : g_direct
            assign tail_vld = rd_acc;
            assign tail     = resp_in;
        end
    endgenerate

    // Response fields hold their last value between strobes.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            bus.rd_data_valid <= 1'b0;
            bus.rd_data       <= '0;
            bus.rd_data_tag   <= '0;
            bus.errstat       <= '0;
            bus.dinv          <= 1'b0;
        end else begin
            bus.rd_data_valid <= tail_vld;
            if (tail_vld) begin
                bus.rd_data     <= tail.data;
                bus.rd_data_tag <= tail.tag;
                bus.errstat     <= tail.errstat;
                bus.dinv        <= tail.dinv;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            if (rd_acc && !(&rd_count_q)) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (wr_acc && !req_err && !(&wr_count_q)) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if ((bad_acc || ((rd_acc || wr_acc) && req_err)) && !(&err_count_q)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign bus.rd_count  = rd_count_q;
    assign bus.wr_count  = wr_count_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_hmc_cmd_responder.sv
// Directed-vector bench for hmc_cmd_responder with a response scoreboard.
// Honours HMC_RESP_REQ_CHECK_EN the same way the design does.
module tb_hmc_cmd_responder;
    localparam int unsigned LATENCY = 8;
    localparam logic [3:0]  CMD_WR  = 4'h1;
    localparam logic [3:0]  CMD_RD  = 4'h2;

    typedef struct {
        logic [5:0]   tag;
        logic [127:0] data;
        logic [6:0]   errstat;
        logic         dinv;
        int           due;
    } exp_t;

    logic rx_clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;
    int   exp_rd, exp_wr, exp_err;
    exp_t exp_q[$];
    logic [127:0] model [int unsigned];

    hmc_cmd_responder_if #(.TAG_WIDTH(6), .SIZE_WIDTH(4), .ADDR_WIDTH(34), .DATA_WIDTH(128)) bus ();

    hmc_cmd_responder #(
        .TAG_WIDTH(6), .SIZE_WIDTH(4), .ADDR_WIDTH(34), .DATA_WIDTH(128),
        .MEM_DEPTH_LOG2(10), .LATENCY(LATENCY), .CMD_WR(CMD_WR), .CMD_RD(CMD_RD)
    ) dut (
        .rx_clk(rx_clk),
        .rst   (rst),
        .bus   (bus)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    initial cyc = 0;
    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding read at its due cycle.
    always @(negedge rx_clk) begin
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            check("rsp_missed", 128'(exp_q[0].tag), 128'hFFFF);
            void'(exp_q.pop_front());
        end
        if (bus.rd_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 128'(bus.rd_data_tag), 128'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("rsp_cycle", 128'(cyc), 128'(e.due));
                check("rsp_tag", 128'(bus.rd_data_tag), 128'(e.tag));
                check("rsp_data", bus.rd_data, e.data);
                check("rsp_errstat", 128'(bus.errstat), 128'(e.errstat));
                check("rsp_dinv", 128'(bus.dinv), 128'(e.dinv));
            end
        end
    end

    task automatic push_rd(input logic [33:0] a, input logic [5:0] t, input logic [3:0] sz);
        exp_t        e;
        logic [9:0]  wi;
        logic [19:0] hi;
        wi        = a[13:4];
        hi        = a[33:14];
        e.tag     = t;
        e.due     = cyc + LATENCY;
        e.errstat = 7'h00;
        e.dinv    = 1'b0;
        e.data    = model[32'(wi)];
`ifdef HMC_RESP_REQ_CHECK_EN
        if (sz != 4'd1) begin
            e.errstat = 7'h01;
            e.dinv    = 1'b1;
            e.data    = '0;
            exp_err++;
        end else if (hi != 20'd0) begin
            e.errstat = 7'h02;
            e.dinv    = 1'b1;
            e.data    = '0;
            exp_err++;
        end
`else
        if (sz == 4'd0 && hi == 20'hFFFFF) e.dinv = 1'b0;
`endif
        exp_rd++;
        exp_q.push_back(e);
    endtask

    // Tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [33:0] a, input logic [127:0] d);
        logic [9:0] wi;
        wi = a[13:4];
        bus.cmd_valid = 1'b1; bus.cmd = CMD_WR; bus.addr = a; bus.size = 4'd1;
        bus.wr_data = d; bus.wr_data_valid = 1'b1;
        @(negedge rx_clk);
        check("wr_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        check("wr_data_ready", 128'(bus.wr_data_ready), 128'd1);
        model[32'(wi)] = d;
        exp_wr++;
        @(posedge rx_clk); #1;
        bus.cmd_valid = 1'b0; bus.wr_data_valid = 1'b0;
    endtask

    task automatic rd(input logic [33:0] a, input logic [5:0] t, input logic [3:0] sz);
        bus.cmd_valid = 1'b1; bus.cmd = CMD_RD; bus.addr = a; bus.size = sz; bus.tag = t;
        @(negedge rx_clk);
        check("rd_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        push_rd(a, t, sz);
        @(posedge rx_clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge rx_clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 128'(exp_q.size()), 128'd0);
            exp_q.delete();
        end
    endtask

    task automatic check_counts(input string where);
        check({where, "_rd_count"}, 128'(bus.rd_count), 128'(exp_rd));
        check({where, "_wr_count"}, 128'(bus.wr_count), 128'(exp_wr));
        check({where, "_err_count"}, 128'(bus.err_count), 128'(exp_err));
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_rd = 0; exp_wr = 0; exp_err = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd = 4'h0; bus.addr = '0; bus.size = 4'd1; bus.tag = '0;
        bus.wr_data = '0; bus.wr_data_valid = 1'b0; bus.stall = 1'b0;

        // Reset state, with a read offered during reset.
        repeat (3) @(posedge rx_clk);
        #1;
        bus.cmd_valid = 1'b1; bus.cmd = CMD_RD;
        @(negedge rx_clk);
        check("rst_cmd_ready", 128'(bus.cmd_ready), 128'd0);
        check("rst_rd_valid", 128'(bus.rd_data_valid), 128'd0);
        check("rst_rd_data", bus.rd_data, 128'd0);
        check("rst_rd_tag", 128'(bus.rd_data_tag), 128'd0);
        check("rst_errstat", 128'(bus.errstat), 128'd0);
        check("rst_dinv", 128'(bus.dinv), 128'd0);
        check_counts("rst");
        @(posedge rx_clk); #1;
        rst = 1'b0; bus.cmd_valid = 1'b0;

        // Write then read the same word on the very next cycle.
        wr(34'h100, {16{8'hA5}});
        rd(34'h100, 6'd5, 4'd1);
        wait_idle();
        check_counts("basic");
        repeat (3) @(posedge rx_clk);
        #1;
        check("hold_data", bus.rd_data, {16{8'hA5}});
        check("hold_tag", 128'(bus.rd_data_tag), 128'd5);

        // 32 back-to-back reads after filling words 0..31.
        for (int i = 0; i < 32; i++) wr(34'(i * 16), {32'hC0DE0000 + 32'(i), 96'(i * 7 + 1)});
        for (int i = 0; i < 32; i++) rd(34'(i * 16), 6'(i), 4'd1);
        wait_idle();
        check_counts("b2b");

        // Write command waits for its payload.
        bus.cmd_valid = 1'b1; bus.cmd = CMD_WR; bus.addr = 34'h3F0; bus.size = 4'd1;
        bus.wr_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        for (int i = 0; i < 5; i++) begin
            @(negedge rx_clk);
            check("wait_cmd_ready", 128'(bus.cmd_ready), 128'd0);
            check("wait_wr_ready", 128'(bus.wr_data_ready), 128'd0);
            @(posedge rx_clk); #1;
        end
        bus.wr_data_valid = 1'b1;
        @(negedge rx_clk);
        check("late_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        check("late_wr_ready", 128'(bus.wr_data_ready), 128'd1);
        model[32'd63] = bus.wr_data;
        exp_wr++;
        @(posedge rx_clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge rx_clk);
        check("orphan_data_ready", 128'(bus.wr_data_ready), 128'd0);
        check("orphan_cmd_ready", 128'(bus.cmd_ready), 128'd0);
        @(posedge rx_clk); #1;
        bus.wr_data_valid = 1'b0;
        rd(34'h3F0, 6'd40, 4'd1);
        wait_idle();
        check_counts("late_wr");

        // Backpressure holds a pending read for 10 cycles.
        bus.stall = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd = CMD_RD; bus.addr = 34'h20; bus.size = 4'd1; bus.tag = 6'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge rx_clk);
            check("stall_cmd_ready", 128'(bus.cmd_ready), 128'd0);
            @(posedge rx_clk); #1;
        end
        bus.stall = 1'b0;
        rd(34'h20, 6'd9, 4'd1);
        wait_idle();

        // Unknown command: accepted, counted, no response.
        bus.cmd_valid = 1'b1; bus.cmd = 4'hF;
        @(negedge rx_clk);
        check("bad_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        check("bad_wr_ready", 128'(bus.wr_data_ready), 128'd0);
        exp_err++;
        @(posedge rx_clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (LATENCY + 4) @(posedge rx_clk);
        #1;
        check_counts("bad_cmd");

        // Out-of-range address and non-unit size.
        rd(34'h2_0000_0000, 6'd7, 4'd1);
        rd(34'h40, 6'd3, 4'd2);
        wait_idle();
        check_counts("req_chk");

        // Reset with four reads in flight discards their responses.
        for (int i = 1; i <= 4; i++) rd(34'(i * 16), 6'(20 + i), 4'd1);
        rst = 1'b1;
        exp_q.delete();
        exp_rd = 0; exp_wr = 0; exp_err = 0;
        @(posedge rx_clk); #1;
        rst = 1'b0;
        repeat (LATENCY + 12) @(posedge rx_clk);
        #1;
        check("post_rst_valid", 128'(bus.rd_data_valid), 128'd0);
        check("post_rst_data", bus.rd_data, 128'd0);
        check_counts("mid_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
